// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the memory responder
package mem_responder_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [31:0] FAULT_DATA  = 32'hDEAD_BEEF;
  localparam logic [31:0] IO_PORT_OFS = 32'd0;
  localparam logic [31:0] IO_STAT_OFS = 32'd1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_responder_ram.sv
// rtl/mem_responder_ram.sv - single-port synchronous RAM, 32-bit words, registered read
module mem_responder_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  // Write port plus read-first registered read of the same address
  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU bus memory responder with RAM, I/O window and post-reset clear (MEM_RESPONDER_CLEAR_EN)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] datao,
  input  logic        rw,
  output logic [31:0] data,
  output logic        busy,
  output logic [31:0] io_out,
  output logic        io_valid,
  output logic        fault
);

  localparam int          DEPTH     = 2**ADDR_W;
  localparam logic [31:0] RAM_LIMIT = 32'(DEPTH);

  state_t            r_state;
  state_t            w_state_next;

  logic              w_busy;
  logic              w_serve;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_ram_wdata;
  logic [31:0]       w_ram_rdata;

  logic              w_in_ram;
  logic              w_is_port;
  logic              w_is_stat;
  logic              w_is_fault;
  logic              w_rd;
  logic              w_wr;

  logic              r_rd_ram;
  logic [31:0]       r_data_hold;
  logic [31:0]       r_io_out;
  logic              r_io_valid;
  logic              r_fault;

  // Full 32-bit compares so no upper-bit aliasing into RAM or the I/O window
  assign w_in_ram   = (address < RAM_LIMIT);
  assign w_is_port  = (address == IO_BASE + IO_PORT_OFS);
  assign w_is_stat  = (address == IO_BASE + IO_STAT_OFS);
  assign w_is_fault = ~w_in_ram & ~w_is_port & ~w_is_stat;
  assign w_rd       = w_serve & (rw == RW_READ);
  assign w_wr       = w_serve & (rw == RW_WRITE);

`ifdef MEM_RESPONDER_CLEAR_EN
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

  logic [ADDR_W:0] r_clr_idx;
  logic            w_clr_done;

  assign w_clr_done = (r_clr_idx == CLR_LAST);

  // Clear index walks the RAM one word per cycle while in INIT
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_idx <= '0;
    end else if (r_state == INIT) begin
      r_clr_idx <= r_clr_idx + CLR_ONE;
    end
  end

  // State register: reset always restarts the clear
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leave INIT once the last word has been cleared
  always_comb begin
    w_state_next = r_state;
    if (r_state == INIT && w_clr_done) begin
      w_state_next = SERVE;
    end
  end
`else
  // State register: without the clear, reset lands directly in SERVE
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SERVE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: SERVE is the only reachable state
  always_comb begin
    w_state_next = SERVE;
  end
`endif

  // State outputs: busy flag and the clear/bus mux onto the RAM port
  always_comb begin
    w_busy      = 1'b0;
    w_serve     = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = address[ADDR_W-1:0];
    w_ram_wdata = datao;
    if (r_state == SERVE) begin
      w_serve  = ~reset;
      w_ram_we = ~reset & w_in_ram & (rw == RW_WRITE);
    end
`ifdef MEM_RESPONDER_CLEAR_EN
    else begin
      w_busy      = 1'b1;
      w_ram_we    = ~reset;
      w_ram_addr  = r_clr_idx[ADDR_W-1:0];
      w_ram_wdata = '0;
    end
`endif
  end

  mem_responder_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  // Bus datapath: read-data hold, output port, valid pulse and sticky fault
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ram    <= 1'b0;
      r_data_hold <= '0;
      r_io_out    <= '0;
      r_io_valid  <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_rd_ram   <= w_rd & w_in_ram;
      r_io_valid <= w_wr & w_is_port;
      if (w_wr & w_is_port) begin
        r_io_out <= datao;
      end
      if ((w_rd | w_wr) & w_is_fault) begin
        r_fault <= 1'b1;
      end
      // RAM read data is captured a cycle late so it holds until the next read
      if (w_rd & w_is_port) begin
        r_data_hold <= r_io_out;
      end else if (w_rd & w_is_stat) begin
        r_data_hold <= {30'b0, r_fault, w_busy};
      end else if (w_rd & w_is_fault) begin
        r_data_hold <= FAULT_DATA;
      end else if (r_rd_ram) begin
        r_data_hold <= w_ram_rdata;
      end
    end
  end

  assign data     = r_rd_ram ? w_ram_rdata : r_data_hold;
  assign busy     = w_busy;
  assign io_out   = r_io_out;
  assign io_valid = r_io_valid;
  assign fault    = r_fault;

endmodule
